// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, optional first-word-fall-through read port and sticky overflow/underflow
// error flags that software clears with err_clr.
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 16,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4,
  parameter bit FWFT       = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_empty,
  output logic                          almost_full,
  output logic [$clog2(DATA_DEPTH):0]   fifo_cnt,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_r [DATA_DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         cnt_r;
  logic                  overflow_r;
  logic                  underflow_r;

  logic                  full_s;
  logic                  empty_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;

  // Status flags decode directly from the registered count so they move with it.
  always_comb begin
    empty_s  = (cnt_r == CW'(0));
    full_s   = (cnt_r == CW'(DATA_DEPTH));
    wr_acc_s = wr_en & ~full_s;
    rd_acc_s = rd_en & ~empty_s;
  end

  assign empty        = empty_s;
  assign full         = full_s;
  assign almost_empty = (cnt_r <= CW'(AE_LEVEL));
  assign almost_full  = (cnt_r >= CW'(AF_LEVEL));
  assign fifo_cnt     = cnt_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

  // Storage array; contents survive reset, but reset still blocks a write on that edge.
  always_ff @(posedge clk) begin
    if (wr_acc_s && !rst) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Write/read pointers advance only on accepted accesses; power-of-two depth wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
    end
  end

  // Occupancy count: simultaneous accepted read and write leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CW'(0);
    end else begin
      case ({wr_acc_s, rd_acc_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_en && full_s) begin
        overflow_r <= 1'b1;
      end else if (err_clr) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
      if (rd_en && empty_s) begin
        underflow_r <= 1'b1;
      end else if (err_clr) begin
        underflow_r <= 1'b0;
      end else begin
        underflow_r <= underflow_r;
      end
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is presented continuously; a read simply advances past it.
      assign data_out = mem_r[rd_ptr_r];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_r;

      // Registered read data, loaded only on an accepted read and held otherwise.
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_r <= DATA_WIDTH'(0);
        end else if (rd_acc_s) begin
          dout_r <= mem_r[rd_ptr_r];
        end else begin
          dout_r <= dout_r;
        end
      end

      assign data_out = dout_r;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed self-checking bench for sync_fifo_flags: a standard-read instance and a
// first-word-fall-through instance, exercised scenario by scenario.
module tb_sync_fifo_flags;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       wr_en, rd_en, err_clr;
  logic [7:0] data_out;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;
  logic [4:0] fifo_cnt;

  logic       b_wr_en, b_rd_en;
  logic [7:0] b_data_out;
  logic       b_empty, b_full, b_almost_empty, b_almost_full, b_overflow, b_underflow;
  logic [4:0] b_fifo_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  sync_fifo_flags #(.DATA_WIDTH(8), .DATA_DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1'b0)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en), .err_clr(err_clr),
    .data_out(data_out), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .fifo_cnt(fifo_cnt), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_flags #(.DATA_WIDTH(8), .DATA_DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1'b1)) dut_fwft (
    .clk(clk), .rst(rst), .data_in(data_in), .wr_en(b_wr_en), .rd_en(b_rd_en), .err_clr(err_clr),
    .data_out(b_data_out), .empty(b_empty), .full(b_full), .almost_empty(b_almost_empty),
    .almost_full(b_almost_full), .fifo_cnt(b_fifo_cnt), .overflow(b_overflow), .underflow(b_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); rst = 1'b0;
    total_cnt++; if (fifo_cnt !== 5'd0) $display("FAIL reset_cnt got %0d want 0", fifo_cnt); else pass_cnt++;
    total_cnt++;
    if ({empty, full, almost_empty, almost_full} !== 4'b1010)
      $display("FAIL reset_flags got %b want 1010", {empty, full, almost_empty, almost_full});
    else pass_cnt++;
    total_cnt++;
    if ({overflow, underflow} !== 2'b00) $display("FAIL reset_err got %b want 00", {overflow, underflow}); else pass_cnt++;
    total_cnt++; if (data_out !== 8'h00) $display("FAIL reset_dout got %h want 00", data_out); else pass_cnt++;
    total_cnt++; if (b_empty !== 1'b1) $display("FAIL reset_fwft_empty got %b want 1", b_empty); else pass_cnt++;
  endtask

  task automatic test_single();
    data_in = 8'hAA; wr_en = 1'b1; step(); wr_en = 1'b0;
    total_cnt++;
    if ({fifo_cnt, empty} !== {5'd1, 1'b0}) $display("FAIL single_wr got cnt=%0d empty=%b want 1/0", fifo_cnt, empty);
    else pass_cnt++;
    rd_en = 1'b1; step(); rd_en = 1'b0;
    total_cnt++; if (data_out !== 8'hAA) $display("FAIL single_rd got %h want aa", data_out); else pass_cnt++;
    total_cnt++;
    if ({fifo_cnt, empty} !== {5'd0, 1'b1}) $display("FAIL single_empty got cnt=%0d empty=%b want 0/1", fifo_cnt, empty);
    else pass_cnt++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] exp_flags;
      data_in = 8'(i); wr_en = 1'b1; step();
      exp_flags = {(i + 1 == 16), (i + 1 >= 12), (i + 1 <= 4), 1'b0};
      total_cnt++;
      if (fifo_cnt !== 5'(i + 1)) $display("FAIL fill_cnt[%0d] got %0d want %0d", i, fifo_cnt, i + 1); else pass_cnt++;
      total_cnt++;
      if ({full, almost_full, almost_empty, empty} !== exp_flags)
        $display("FAIL fill_flags[%0d] got %b want %b", i, {full, almost_full, almost_empty, empty}, exp_flags);
      else pass_cnt++;
    end
    data_in = 8'hFF; step(); wr_en = 1'b0;
    total_cnt++;
    if ({fifo_cnt, full, overflow} !== {5'd16, 1'b1, 1'b1})
      $display("FAIL overflow got cnt=%0d full=%b ovf=%b want 16/1/1", fifo_cnt, full, overflow);
    else pass_cnt++;
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1; step();
      total_cnt++; if (data_out !== 8'(i)) $display("FAIL drain_data[%0d] got %h want %h", i, data_out, 8'(i)); else pass_cnt++;
      total_cnt++; if (fifo_cnt !== 5'(15 - i)) $display("FAIL drain_cnt[%0d] got %0d want %0d", i, fifo_cnt, 15 - i); else pass_cnt++;
    end
    step(); rd_en = 1'b0;
    total_cnt++;
    if ({underflow, fifo_cnt, data_out} !== {1'b1, 5'd0, 8'h0F})
      $display("FAIL underflow got unf=%b cnt=%0d dout=%h want 1/0/0f", underflow, fifo_cnt, data_out);
    else pass_cnt++;
    err_clr = 1'b1; rd_en = 1'b1; step(); rd_en = 1'b0;
    total_cnt++;
    if ({overflow, underflow} !== 2'b01) $display("FAIL clr_set_wins got %b want 01", {overflow, underflow}); else pass_cnt++;
    step(); err_clr = 1'b0;
    total_cnt++;
    if ({overflow, underflow} !== 2'b00) $display("FAIL err_clr got %b want 00", {overflow, underflow}); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = 8'h10 + 8'(i); step();
    end
    rd_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      logic [7:0] exp_d;
      exp_d = (k < 8) ? 8'h10 + 8'(k) : 8'h20 + 8'(k - 8);
      data_in = 8'h20 + 8'(k); step();
      total_cnt++; if (data_out !== exp_d) $display("FAIL b2b_data[%0d] got %h want %h", k, data_out, exp_d); else pass_cnt++;
      total_cnt++; if (fifo_cnt !== 5'd8) $display("FAIL b2b_cnt[%0d] got %0d want 8", k, fifo_cnt); else pass_cnt++;
    end
    rd_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      data_in = 8'h30 + 8'(i); step();
    end
    total_cnt++; if (full !== 1'b1) $display("FAIL b2b_full got %b want 1", full); else pass_cnt++;
    data_in = 8'hEE; rd_en = 1'b1; step(); wr_en = 1'b0; rd_en = 1'b0;
    total_cnt++;
    if ({fifo_cnt, overflow, data_out} !== {5'd15, 1'b1, 8'h22})
      $display("FAIL full_both got cnt=%0d ovf=%b dout=%h want 15/1/22", fifo_cnt, overflow, data_out);
    else pass_cnt++;
  endtask

  task automatic test_fwft();
    data_in = 8'h5A; b_wr_en = 1'b1; step(); b_wr_en = 1'b0;
    total_cnt++;
    if ({b_empty, b_data_out} !== {1'b0, 8'h5A}) $display("FAIL fwft_first got empty=%b dout=%h want 0/5a", b_empty, b_data_out);
    else pass_cnt++;
    data_in = 8'h3C; b_wr_en = 1'b1; step(); b_wr_en = 1'b0;
    total_cnt++; if (b_data_out !== 8'h5A) $display("FAIL fwft_head got %h want 5a", b_data_out); else pass_cnt++;
    b_rd_en = 1'b1; step(); b_rd_en = 1'b0;
    total_cnt++;
    if ({b_fifo_cnt, b_data_out} !== {5'd1, 8'h3C}) $display("FAIL fwft_pop got cnt=%0d dout=%h want 1/3c", b_fifo_cnt, b_data_out);
    else pass_cnt++;
    b_rd_en = 1'b1; step(); b_rd_en = 1'b0;
    total_cnt++;
    if ({b_empty, b_underflow} !== 2'b10) $display("FAIL fwft_drain got %b want 10", {b_empty, b_underflow}); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; step(); rst = 1'b0;
    rd_en = 1'b1; step(); rd_en = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in = 8'h40 + 8'(i); step();
    end
    wr_en = 1'b0; rd_en = 1'b1; step(); rd_en = 1'b0;
    total_cnt++;
    if ({fifo_cnt, underflow, data_out} !== {5'd9, 1'b1, 8'h40})
      $display("FAIL pre_rst got cnt=%0d unf=%b dout=%h want 9/1/40", fifo_cnt, underflow, data_out);
    else pass_cnt++;
    rst = 1'b1; wr_en = 1'b1; data_in = 8'h99; step(); rst = 1'b0; wr_en = 1'b0;
    total_cnt++;
    if ({fifo_cnt, empty, almost_empty, underflow, overflow, data_out} !== {5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00})
      $display("FAIL mid_rst got cnt=%0d e=%b ae=%b unf=%b ovf=%b dout=%h want 0/1/1/0/0/00",
               fifo_cnt, empty, almost_empty, underflow, overflow, data_out);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    int errs;
    errs = 0;
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = 8'(i); step();
    end
    wr_en = 1'b0; rd_en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rd_en = 1'b0;
    for (int p = 0; p < 3; p++) begin
      wr_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
        data_in = 8'(p * 16 + i) ^ 8'hC3; step();
      end
      wr_en = 1'b0; rd_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
        step();
        total_cnt++;
        if (data_out !== (8'(p * 16 + i) ^ 8'hC3))
          $display("FAIL wrap_data[%0d][%0d] got %h want %h", p, i, data_out, 8'(p * 16 + i) ^ 8'hC3);
        else pass_cnt++;
      end
      rd_en = 1'b0;
      total_cnt++; if (empty !== 1'b1) $display("FAIL wrap_empty[%0d] got %b want 1", p, empty); else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b0; data_in = 8'h00; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    b_wr_en = 1'b0; b_rd_en = 1'b0;
    #2;
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_back_to_back();
    test_fwft();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
